// File: rtl/udp_pkg.sv
// Shared constants and FSM state type for the UDP checksum insertion path.
package udp_pkg;

   localparam int          IPV4_HDR_WORDS = 5;
   // UDP header word 1 (length | checksum) follows the option-less IPv4 header.
   localparam int          UDP_CKSUM_WORD = IPV4_HDR_WORDS + 1;
   localparam logic [15:0] CKSUM_ZERO_SUB = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      BODY = 2'd2
   } cksum_ins_st_t;

endpackage

// File: rtl/udp_axis_reg_slice.sv
// One-stage valid/ready output register; holds its output stable while m_ready is low.
module udp_axis_reg_slice #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] s_data,
   input  logic         s_valid,
   input  logic         s_last,
   output logic         s_ready,
   output logic [W-1:0] m_data,
   output logic         m_valid,
   output logic         m_last,
   input  logic         m_ready
);

   assign s_ready = !m_valid || m_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data  <= '0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
      end else if (s_valid && s_ready) begin
         m_data  <= s_data;
         m_valid <= 1'b1;
         m_last  <= s_last;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/udp_checksum_inserter.sv
// Pops one precomputed UDP checksum per frame and patches it into the checksum word.
// Optional UDP_CKSUM_STAT_EN adds frame / runt statistics counters.
//
// state | meaning
// IDLE  | waiting for a checksum at the FIFO head; input stalled
// HDR   | counting header words up to and including the checksum word
// BODY  | checksum already patched; pass-through until s_last
module udp_checksum_inserter
   import udp_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int CKSUM_WORD = UDP_CKSUM_WORD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   input  logic [DATA_W-1:0] ck_rd_data,
   input  logic              ck_rd_vld,
   output logic              ck_rd_en,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   output logic              m_last,
   input  logic              m_ready,
`ifdef UDP_CKSUM_STAT_EN
   output logic [15:0]       stat_frames,
   output logic [15:0]       stat_runts,
`endif
   output logic              runt_err
);

   localparam logic [2:0] CKW = 3'(CKSUM_WORD);

   cksum_ins_st_t     state_q, state_d;
   logic [2:0]        wcnt_q, wcnt_d;
   logic [15:0]       cksum_q, cksum_d;
   logic [15:0]       cksum_m;
   logic              slice_ready;
   logic              accept;
   logic              at_cksum;
   logic [DATA_W-1:0] patched;
   logic              unused_rsvd;

   assign unused_rsvd = ^ck_rd_data[DATA_W-1:16];

   assign s_ready  = (state_q != IDLE) && slice_ready;
   assign accept   = s_valid && s_ready;
   assign at_cksum = (state_q == HDR) && (wcnt_q == CKW);
   // Zero on the wire means "no checksum", so a computed zero goes out as all-ones.
   assign cksum_m  = (cksum_q == 16'h0000) ? CKSUM_ZERO_SUB : cksum_q;
   assign patched  = at_cksum ? {s_data[DATA_W-1:16], cksum_m} : s_data;
   assign ck_rd_en = accept && s_last;
   assign runt_err = accept && s_last && (state_q == HDR) && (wcnt_q < CKW);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         cksum_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         cksum_q <= cksum_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      cksum_d = cksum_q;
      case (state_q)
         IDLE: begin
            if (ck_rd_vld) begin
               state_d = HDR;
               wcnt_d  = '0;
               cksum_d = ck_rd_data[15:0];
            end
         end
         HDR: begin
            if (accept) begin
               wcnt_d = wcnt_q + 3'd1;
               if (at_cksum) state_d = BODY;
            end
         end
         BODY: ;
         default: state_d = IDLE;
      endcase
      if (accept && s_last) state_d = IDLE;
   end

   udp_axis_reg_slice #(.W(DATA_W)) u_out_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_data  (patched),
      .s_valid (s_valid && (state_q != IDLE)),
      .s_last  (s_last),
      .s_ready (slice_ready),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_last  (m_last),
      .m_ready (m_ready)
   );

`ifdef UDP_CKSUM_STAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_frames <= '0;
         stat_runts  <= '0;
      end else begin
         if (ck_rd_en) stat_frames <= stat_frames + 16'd1;
         if (runt_err) stat_runts  <= stat_runts + 16'd1;
      end
   end
`endif

endmodule
